// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: pipeline (A) ports with priority, load-unit (B) FIFO.
// WB_ARB_STARVE_GUARD_EN builds the B starvation counter and the A stall.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               a_write,
    input  logic [31:0]              a_wr1,
    input  logic [31:0]              a_wr2,
    input  logic [4:0]               a_wa1,
    input  logic [4:0]               a_wa2,
    output logic                     a_stall,
    input  logic                     b_valid,
    input  logic [31:0]              b_data,
    input  logic [4:0]               b_addr,
    output logic                     b_ready,
    output logic [1:0]               write,
    output logic [31:0]              wr1,
    output logic [31:0]              wr2,
    output logic [4:0]               wa1,
    output logic [4:0]               wa2,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t          mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr1;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic [1:0]    pop_n;
    logic          a1_v;
    logic          a2_v;
    logic          h0_v;
    logic          h1_v;
    ent_t          h0;
    ent_t          h1;

    logic [1:0]    n_write;
    logic [31:0]   n_wr1;
    logic [31:0]   n_wr2;
    logic [4:0]    n_wa1;
    logic [4:0]    n_wa2;

    assign b_ready    = (count < CW'(DEPTH)) && rst;
    assign push       = b_valid && b_ready;
    assign fifo_count = count;

    // a_write=10 decodes as no request; a stall hides A entirely
    assign a1_v    = !a_stall && a_write[0];
    assign a2_v    = !a_stall && (a_write == 2'b11);
    assign h0_v    = (count != '0);
    assign h1_v    = (count >= CW'(2));
    assign rd_ptr1 = rd_ptr + AW'(1);
    assign h0      = mem[rd_ptr];
    assign h1      = mem[rd_ptr1];

    always_comb begin
        n_write = 2'b00;
        n_wr1   = '0;
        n_wr2   = '0;
        n_wa1   = '0;
        n_wa2   = '0;
        pop_n   = 2'd0;
        unique case (1'b1)
            a2_v: begin
                n_write = 2'b11;
                n_wr1   = a_wr1;
                n_wa1   = a_wa1;
                n_wr2   = a_wr2;
                n_wa2   = a_wa2;
            end
            (a1_v && !a2_v): begin
                n_write = 2'b01;
                n_wr1   = a_wr1;
                n_wa1   = a_wa1;
                if (h0_v) begin
                    pop_n = 2'd1;
                    // same address as A: A is newer, drop the head
                    if (h0.addr != a_wa1) begin
                        n_write = 2'b11;
                        n_wr2   = h0.data;
                        n_wa2   = h0.addr;
                    end
                end
            end
            (!a1_v && h1_v): begin
                pop_n = 2'd2;
                if (h0.addr == h1.addr) begin
                    n_write = 2'b01;
                    n_wr1   = h1.data;
                    n_wa1   = h1.addr;
                end else begin
                    n_write = 2'b11;
                    n_wr1   = h0.data;
                    n_wa1   = h0.addr;
                    n_wr2   = h1.data;
                    n_wa2   = h1.addr;
                end
            end
            (!a1_v && h0_v && !h1_v): begin
                pop_n   = 2'd1;
                n_write = 2'b01;
                n_wr1   = h0.data;
                n_wa1   = h0.addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: b_addr, data: b_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            write  <= 2'b00;
            wr1    <= '0;
            wr2    <= '0;
            wa1    <= '0;
            wa2    <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_n);
            wr_ptr <= wr_ptr + AW'(push);
            count  <= count + CW'(push) - CW'(pop_n);
            write  <= n_write;
            wr1    <= n_wr1;
            wr2    <= n_wr2;
            wa1    <= n_wa1;
            wa2    <= n_wa2;
        end
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] scnt;
    logic           starved;
    logic           hit;

    assign starved = h0_v && (pop_n == 2'd0);
    assign hit     = starved && (scnt == SCW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt    <= '0;
            a_stall <= 1'b0;
        end else begin
            a_stall <= hit;
            if (!starved || hit) begin
                scnt <= '0;
            end else begin
                scnt <= scnt + SCW'(1);
            end
        end
    end
`else
    logic unused_starve;

    assign unused_starve = (STARVE_LIMIT > 0);
    assign a_stall       = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=4, STARVE_LIMIT=8).
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  a_write;
    logic [31:0] a_wr1;
    logic [31:0] a_wr2;
    logic [4:0]  a_wa1;
    logic [4:0]  a_wa2;
    logic        a_stall;
    logic        b_valid;
    logic [31:0] b_data;
    logic [4:0]  b_addr;
    logic        b_ready;
    logic [1:0]  write;
    logic [31:0] wr1;
    logic [31:0] wr2;
    logic [4:0]  wa1;
    logic [4:0]  wa2;
    logic [2:0]  fifo_count;

    int checks;
    int failures;

    regfile_wb_arbiter #(
        .DEPTH(4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a_write(a_write),
        .a_wr1(a_wr1),
        .a_wr2(a_wr2),
        .a_wa1(a_wa1),
        .a_wa2(a_wa2),
        .a_stall(a_stall),
        .b_valid(b_valid),
        .b_data(b_data),
        .b_addr(b_addr),
        .b_ready(b_ready),
        .write(write),
        .wr1(wr1),
        .wr2(wr2),
        .wa1(wa1),
        .wa2(wa2),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] w, input logic [4:0] wa_1,
                           input logic [31:0] d1, input logic [4:0] wa_2,
                           input logic [31:0] d2);
        a_write = w;
        a_wa1   = wa_1;
        a_wr1   = d1;
        a_wa2   = wa_2;
        a_wr2   = d2;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] ad,
                           input logic [31:0] d);
        b_valid = v;
        b_addr  = ad;
        b_data  = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        check("rst_write", 64'(write), 64'h0);
        check("rst_data", 64'({wr1, wr2}), 64'h0);
        check("rst_addr", 64'({wa1, wa2}), 64'h0);
        check("rst_stall", 64'(a_stall), 64'h0);
        check("rst_ready", 64'(b_ready), 64'h0);
        check("rst_count", 64'(fifo_count), 64'h0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", 64'(b_ready), 64'h1);

        // A on both ports
        drive_a(2'b11, 5'd3, 32'hAA, 5'd4, 32'hBB);
        tick();
        check("a11_write", 64'(write), 64'h3);
        check("a11_p1", 64'({wa1, wr1}), {27'h0, 5'd3, 32'hAA});
        check("a11_p2", 64'({wa2, wr2}), {27'h0, 5'd4, 32'hBB});

        // B entry issues beside a single A write
        drive_a(2'b01, 5'd2, 32'h22, 5'd0, 32'h0);
        drive_b(1'b1, 5'd7, 32'h11);
        tick();
        check("share_w0", 64'(write), 64'h1);
        check("share_cnt0", 64'(fifo_count), 64'h1);
        drive_b(1'b0, 5'd0, 32'h0);
        tick();
        check("share_write", 64'(write), 64'h3);
        check("share_p1", 64'({wa1, wr1}), {27'h0, 5'd2, 32'h22});
        check("share_p2", 64'({wa2, wr2}), {27'h0, 5'd7, 32'h11});
        check("share_cnt", 64'(fifo_count), 64'h0);

        // B entry hit by same-address A write is discarded
        drive_a(2'b01, 5'd5, 32'h55, 5'd0, 32'h0);
        drive_b(1'b1, 5'd5, 32'h77);
        tick();
        check("conf_cnt0", 64'(fifo_count), 64'h1);
        drive_b(1'b0, 5'd0, 32'h0);
        tick();
        check("conf_write", 64'(write), 64'h1);
        check("conf_p1", 64'({wa1, wr1}), {27'h0, 5'd5, 32'h55});
        check("conf_wr2", 64'(wr2), 64'h0);
        check("conf_cnt", 64'(fifo_count), 64'h0);
        drive_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        check("conf_gone", 64'(write), 64'h0);

        // two B entries to the same address merge into one write
        drive_a(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        drive_b(1'b1, 5'd9, 32'h91);
        tick();
        drive_b(1'b1, 5'd9, 32'h92);
        tick();
        check("merge_cnt2", 64'(fifo_count), 64'h2);
        drive_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        tick();
        check("merge_write", 64'(write), 64'h1);
        check("merge_p1", 64'({wa1, wr1}), {27'h0, 5'd9, 32'h92});
        check("merge_wr2", 64'(wr2), 64'h0);
        check("merge_cnt", 64'(fifo_count), 64'h0);

        // two distinct B entries drain together, in order
        drive_a(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        drive_b(1'b1, 5'd10, 32'hA0);
        tick();
        drive_b(1'b1, 5'd11, 32'hB0);
        tick();
        drive_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        tick();
        check("pair_write", 64'(write), 64'h3);
        check("pair_p1", 64'({wa1, wr1}), {27'h0, 5'd10, 32'hA0});
        check("pair_p2", 64'({wa2, wr2}), {27'h0, 5'd11, 32'hB0});
        check("pair_cnt", 64'(fifo_count), 64'h0);

        // a_write=10 acts as no request
        drive_a(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        drive_b(1'b1, 5'd13, 32'hD0);
        tick();
        drive_b(1'b0, 5'd0, 32'h0);
        drive_a(2'b10, 5'd13, 32'hEE, 5'd14, 32'hFF);
        tick();
        check("a10_write", 64'(write), 64'h1);
        check("a10_p1", 64'({wa1, wr1}), {27'h0, 5'd13, 32'hD0});
        check("a10_cnt", 64'(fifo_count), 64'h0);

        // B starved behind continuous A traffic
        drive_a(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        drive_b(1'b1, 5'd12, 32'hC0);
        tick();
        drive_b(1'b0, 5'd0, 32'h0);
`ifdef WB_ARB_STARVE_GUARD_EN
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("starve_stall_%0d", k), 64'(a_stall),
                  64'(k == 8));
        end
        tick();
        check("starve_write", 64'(write), 64'h1);
        check("starve_p1", 64'({wa1, wr1}), {27'h0, 5'd12, 32'hC0});
        check("starve_end", 64'(a_stall), 64'h0);
        check("starve_cnt", 64'(fifo_count), 64'h0);
`else
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("nostarve_%0d", k),
                  64'({a_stall, write, fifo_count}), {58'h0, 1'b0, 2'b11, 3'd1});
        end
        drive_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        check("nostarve_write", 64'(write), 64'h1);
        check("nostarve_p1", 64'({wa1, wr1}), {27'h0, 5'd12, 32'hC0});
        check("nostarve_cnt", 64'(fifo_count), 64'h0);
`endif

        // fill the FIFO, hold a push while full, then reset mid-stream
        drive_a(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        for (int k = 0; k < 4; k++) begin
            drive_b(1'b1, 5'(20 + k), 32'(32'hF0 + k));
            tick();
        end
        check("full_cnt", 64'(fifo_count), 64'h4);
        check("full_ready", 64'(b_ready), 64'h0);
        drive_b(1'b1, 5'd30, 32'hBAD);
        tick();
        check("full_hold", 64'(fifo_count), 64'h4);
        rst = 1'b0;
        #1;
        check("mrst_cnt", 64'(fifo_count), 64'h0);
        check("mrst_write", 64'(write), 64'h0);
        check("mrst_ready", 64'(b_ready), 64'h0);
        check("mrst_stall", 64'(a_stall), 64'h0);
        drive_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("no_stale_%0d", k), 64'({write, fifo_count}), 64'h0);
        end

        // first edge after reset accepts A and B together
        rst = 1'b0;
        #2;
        rst = 1'b1;
        drive_a(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
        drive_b(1'b1, 5'd4, 32'h44);
        tick();
        check("post_write", 64'(write), 64'h1);
        check("post_p1", 64'({wa1, wr1}), {27'h0, 5'd3, 32'h33});
        check("post_cnt", 64'(fifo_count), 64'h1);
        drive_a(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        tick();
        check("post_b", 64'({write, wa1, wr1}), {25'h0, 2'b01, 5'd4, 32'h44});
        check("post_cnt0", 64'(fifo_count), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: number of entries in the requester-B write FIFO; a power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 8: number of consecutive starved cycles before requester A is stalled.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 a_write  in  2  pipeline write-back valids: 00 none, 01 port 1 only, 11 both ports; 10 is treated as 00.
REQ-006 a_wr1, a_wr2  in  32  pipeline write data.
REQ-007 a_wa1, a_wa2  in  5  pipeline write addresses.
REQ-008 a_stall  out  1  registered; while it is 1, upstream holds and the arbiter ignores the A inputs.
REQ-009 b_valid  in  1  load-unit write request.
REQ-010 b_data  in  32  load-unit write data.
REQ-011 b_addr  in  5  load-unit write address.
REQ-012 b_ready  out  1  FIFO can accept a write; equals (count < DEPTH) and rst high.
REQ-013 write  out  2  register-file write enables, encoded 00, 01 or 11.
REQ-014 wr1, wr2  out  32  register-file write data.
REQ-015 wa1, wa2  out  5  register-file write addresses.
REQ-016 fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 All register-file outputs are registered: an input accepted in cycle N appears on write/wr/wa in cycle N+1.
REQ-018 A B entry is pushed when b_valid and b_ready are both 1 at a clock edge; a push and a pop in the same cycle are both performed.
REQ-019 Requester A has priority: a_write=01 takes port 1; a_write=11 takes ports 1 and 2, with wr1/wa1 fed from a_wr1/a_wa1 and wr2/wa2 from a_wr2/a_wa2.
REQ-020 When a_write=01 and the FIFO is not empty, the head entry issues on port 2 and write=11.
REQ-021 When a_write=00 (or A is ignored), the head entry issues on port 1 and head+1, if present, issues on port 2.
REQ-022 When both head and head+1 issue and their addresses are equal, both entries are popped and only head+1 is written, on port 1 with write=01.
REQ-023 Address conflict: any B entry eligible to issue whose address equals a valid A address in the same cycle is popped and discarded, because A is newer; its port stays free for the next B entry only if that entry was already eligible.
REQ-024 Issued and discarded entries leave the FIFO in order; the read and write pointers wrap modulo DEPTH.
REQ-025 Starvation counter: increments each cycle the FIFO is non-empty and no B entry is popped; clears on any pop or when the FIFO is empty.
REQ-026 When the counter reaches STARVE_LIMIT, a_stall is 1 for exactly the next cycle and the counter clears; in that cycle B drains under REQ-021.
REQ-027 A FIFO push while full is impossible because b_ready=0; a b_valid held while full waits until space is available.

Reset
REQ-028 While rst=0: write=00, wr1=wr2=0, wa1=wa2=0, a_stall=0, b_ready=0, FIFO empty (fifo_count=0), starvation counter 0.
REQ-029 Reset asserted mid-operation discards all FIFO contents and any pending stall immediately; no write is issued for the discarded entries.
REQ-030 After rst returns to 1, the first rising clock edge can accept both A and B inputs.

Configuration
REQ-031 Macro WB_ARB_STARVE_GUARD_EN defined: the starvation counter and stall behaviour of REQ-025/REQ-026 are built in.
REQ-032 WB_ARB_STARVE_GUARD_EN undefined: no counter is built, a_stall is tied to 0, and B issues only on ports left free by A.

Verification
REQ-033 Reset, then a_write=11 with addresses 3/4 and data AA/BB -> next cycle write=11, wa1=3, wr1=AA, wa2=4, wr2=BB.
REQ-034 Push B (addr 7, data 11) while a_write=01 (addr 2) -> next cycle write=11, wa1=2, wa2=7, fifo_count returns to 0.
REQ-035 Push B (addr 5) while a_write=01 to addr 5 -> the B entry is discarded, write=01, wa1=5 with A's data, and fifo_count=0.
REQ-036 Push B entries at addr 9 then addr 9 with a_write=00 -> single write=01, wa1=9 carrying the second entry's data, and fifo_count=0.
REQ-037 With the macro defined and STARVE_LIMIT=8: one B entry, a_write=11 held continuously -> a_stall=1 on the 9th cycle, then the B entry is written on port 1.
REQ-038 Fill the FIFO to 4 entries -> b_ready=0; assert rst=0 for one cycle -> fifo_count=0, write=00, and no queued entry is ever written.
